// File: rtl/mult_accum.sv
// mult_accum: sums groups of consecutive 64-bit products into wide results, 2-entry result queue with sticky drop.
// Define MULT_ACCUM_SAT_EN for saturating accumulation; default build wraps modulo 2^ACCW.
module mult_accum #(
    parameter int ACCW = 72,
    parameter int CNTW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic [CNTW-1:0] len,
    input  logic            vldin,
    input  logic [63:0]     din,
    output logic            vldout,
    input  logic            rdy,
    output logic [ACCW-1:0] sum,
    output logic            busy,
    output logic            drop
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] ACC  = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [CNTW-1:0] rem_q, rem_d;
    logic [ACCW-1:0] acc_q, acc_d;
    logic [ACCW-1:0] q0_q, q0_d, q1_q, q1_d;
    logic [1:0]      cnt_q, cnt_d;
    logic            drop_q, drop_d;
    logic [ACCW-1:0] add_res, grp_val;
    logic            push, pop, last;

`ifdef MULT_ACCUM_SAT_EN
    logic [ACCW:0] add_full;
    assign add_full = {1'b0, acc_q} + (ACCW+1)'(din);
    assign add_res  = add_full[ACCW] ? {ACCW{1'b1}} : add_full[ACCW-1:0];
`else
    assign add_res  = acc_q + ACCW'(din);
`endif

    // rem holds products still owed after the current one; len-1 wraps so len=0 yields a 2^CNTW group
    assign grp_val = (state_q == IDLE) ? ACCW'(din) : add_res;
    assign last    = (state_q == IDLE) ? (len == CNTW'(1)) : (rem_q == CNTW'(1));
    assign pop     = vldout && rdy;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        acc_d   = acc_q;
        push    = 1'b0;
        if (vldin) begin
            acc_d   = grp_val;
            rem_d   = (state_q == IDLE) ? len - CNTW'(1) : rem_q - CNTW'(1);
            push    = last;
            state_d = last ? IDLE : ACC;
        end
        if (clr) begin
            state_d = IDLE;
            rem_d   = '0;
            acc_d   = '0;
            push    = 1'b0;
        end
    end

    // queue is a two-stage shift register with q0 as head, so sum is a plain register
    always_comb begin
        q0_d   = q0_q;
        q1_d   = q1_q;
        cnt_d  = cnt_q;
        drop_d = drop_q;
        if (pop) begin
            q0_d  = (cnt_q == 2'd2) ? q1_q : q0_q;
            cnt_d = cnt_q - 2'd1;
        end
        if (push) begin
            if (cnt_d == 2'd2) begin
                drop_d = 1'b1;
            end else begin
                q0_d  = (cnt_d == 2'd0) ? grp_val : q0_d;
                q1_d  = (cnt_d == 2'd1) ? grp_val : q1_d;
                cnt_d = cnt_d + 2'd1;
            end
        end
        if (clr) begin
            cnt_d  = 2'd0;
            drop_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            acc_q   <= '0;
            q0_q    <= '0;
            q1_q    <= '0;
            cnt_q   <= 2'd0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            acc_q   <= acc_d;
            q0_q    <= q0_d;
            q1_q    <= q1_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
        end
    end

    assign vldout = cnt_q != 2'd0;
    assign sum    = q0_q;
    assign busy   = state_q == ACC;
    assign drop   = drop_q;
endmodule

// File: tb/tb_mult_accum.sv
// tb_mult_accum: directed stimulus with a queue-based reference model checked every cycle.
module tb_mult_accum;
    localparam int ACCW = 64;
    localparam int CNTW = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            clr = 1'b0;
    logic            vldin = 1'b0;
    logic            rdy = 1'b1;
    logic [CNTW-1:0] len = 8'd1;
    logic [63:0]     din = '0;
    logic            vldout, busy, drop;
    logic [ACCW-1:0] sum;
    int              n_chk = 0;
    int              n_fail = 0;

    always #5 clk = ~clk;

    mult_accum #(.ACCW(ACCW), .CNTW(CNTW)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .len(len), .vldin(vldin), .din(din),
        .vldout(vldout), .rdy(rdy), .sum(sum), .busy(busy), .drop(drop)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: running group sum plus a list of pending results
    logic [64:0] m_acc = '0;
    int          m_rem = 0;
    bit          m_busy = 1'b0;
    bit          m_drop = 1'b0;
    logic [63:0] m_q[$];

    always @(posedge clk or negedge rst_n) begin : model
        bit pop_e, push_e;
        if (!rst_n) begin
            m_q.delete();
            m_busy = 1'b0;
            m_drop = 1'b0;
            m_rem  = 0;
        end else if (clr) begin
            m_q.delete();
            m_busy = 1'b0;
            m_drop = 1'b0;
        end else begin
            pop_e  = (m_q.size() != 0) && rdy;
            push_e = 1'b0;
            if (vldin) begin
                if (!m_busy) begin
                    m_rem = (len == 0) ? (1 << CNTW) : int'(len);
                    m_acc = {1'b0, din};
                end else begin
                    m_acc = m_acc + {1'b0, din};
                end
`ifdef MULT_ACCUM_SAT_EN
                if (m_acc[64]) m_acc = {1'b0, {64{1'b1}}};
`else
                m_acc[64] = 1'b0;
`endif
                m_rem--;
                push_e = (m_rem == 0);
                m_busy = !push_e;
            end
            if (pop_e) void'(m_q.pop_front());
            if (push_e) begin
                if (m_q.size() < 2) m_q.push_back(m_acc[63:0]);
                else m_drop = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        chk("vldout", vldout, m_q.size() != 0);
        if (m_q.size() != 0) chk("sum", sum, m_q[0]);
        chk("busy", busy, m_busy);
        chk("drop", drop, m_drop);
    end

    task automatic step(input logic v, input logic [63:0] d);
        @(negedge clk);
        vldin = v;
        din   = d;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 64'd0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_vldout", vldout, 0);
        chk("rst_sum", sum, 0);
        chk("rst_busy", busy, 0);
        chk("rst_drop", drop, 0);
        // len=3 group, with a len change mid-group that must be ignored
        len = 8'd3;
        step(1'b1, 64'd5);
        step(1'b1, 64'd7);
        chk("g3_busy1", busy, 1);
        len = 8'd7;
        step(1'b1, 64'd9);
        chk("g3_busy2", busy, 1);
        step(1'b0, 64'd0);
        chk("g3_vld", vldout, 1);
        chk("g3_sum", sum, 64'd21);
        chk("g3_busy3", busy, 0);
        step(1'b0, 64'd0);
        chk("g3_pulse", vldout, 0);
        // len=1 back-to-back
        len = 8'd1;
        step(1'b1, 64'd1);
        step(1'b1, 64'd2);
        chk("l1_s1", sum, 64'd1);
        step(1'b1, 64'd3);
        chk("l1_s2", sum, 64'd2);
        step(1'b0, 64'd0);
        chk("l1_s3", sum, 64'd3);
        step(1'b0, 64'd0);
        chk("l1_end", vldout, 0);
        chk("l1_drop", drop, 0);
        // overflow of the queue while stalled
        rdy = 1'b0;
        step(1'b1, 64'd10);
        step(1'b1, 64'd20);
        step(1'b1, 64'd30);
        step(1'b0, 64'd0);
        chk("ovf_vld", vldout, 1);
        chk("ovf_head", sum, 64'd10);
        chk("ovf_drop", drop, 1);
        idle(2);
        chk("ovf_hold", sum, 64'd10);
        rdy = 1'b1;
        step(1'b0, 64'd0);
        chk("ovf_second", sum, 64'd20);
        step(1'b0, 64'd0);
        chk("ovf_empty", vldout, 0);
        chk("ovf_sticky", drop, 1);
        clr = 1'b1;
        step(1'b0, 64'd0);
        clr = 1'b0;
        chk("clr_drop", drop, 0);
        // len=0 means 256 products
        len = 8'd0;
        repeat (255) step(1'b1, 64'd1);
        step(1'b0, 64'd0);
        idle(3);
        chk("l0_noresult", vldout, 0);
        chk("l0_busy", busy, 1);
        step(1'b1, 64'd1);
        step(1'b0, 64'd0);
        chk("l0_vld", vldout, 1);
        chk("l0_sum", sum, 64'd256);
        idle(1);
        // overflow of the accumulator
        len = 8'd2;
        step(1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        step(1'b1, 64'd2);
        step(1'b0, 64'd0);
`ifdef MULT_ACCUM_SAT_EN
        chk("ovr_sum", sum, 64'hFFFF_FFFF_FFFF_FFFF);
`else
        chk("ovr_sum", sum, 64'd1);
`endif
        idle(1);
        // clr mid-group, with vldin in the clr cycle ignored
        len = 8'd4;
        step(1'b1, 64'd1);
        step(1'b1, 64'd1);
        step(1'b1, 64'd1);
        clr = 1'b1;
        step(1'b1, 64'd1);
        clr = 1'b0;
        step(1'b1, 64'd1);
        step(1'b1, 64'd1);
        step(1'b1, 64'd1);
        step(1'b0, 64'd0);
        chk("clr_vld", vldout, 1);
        chk("clr_sum", sum, 64'd4);
        idle(1);
        // reset mid-group
        step(1'b1, 64'd1);
        step(1'b1, 64'd1);
        step(1'b0, 64'd0);
        #2 rst_n = 1'b0;
        step(1'b0, 64'd0);
        rst_n = 1'b1;
        step(1'b1, 64'd1);
        step(1'b1, 64'd1);
        step(1'b1, 64'd1);
        step(1'b1, 64'd1);
        step(1'b0, 64'd0);
        chk("rstg_sum", sum, 64'd4);
        idle(1);
        // reset while a result is waiting
        len = 8'd1;
        rdy = 1'b0;
        step(1'b1, 64'd7);
        step(1'b0, 64'd0);
        chk("rstq_vld", vldout, 1);
        chk("rstq_sum", sum, 64'd7);
        #2 rst_n = 1'b0;
        #1 chk("rstq_drop_now", vldout, 0);
        step(1'b0, 64'd0);
        rst_n = 1'b1;
        rdy = 1'b1;
        idle(2);
        chk("rstq_lost", vldout, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
